ghist_ctrl: RTL and testbench
=============================

GHIST_CTRL -- requirements
Module: ghist_ctrl

Interface
REQ-001 Parameter GHB_SIZE, default 8: global history width, equal to the PHT index width.
REQ-002 Parameter DEPTH, default 8, power of two: in-flight branch checkpoint FIFO depth.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low: state clears immediately while reset==0.
REQ-005 pc  in  32  fetch PC of the branch being predicted.
REQ-006 pred_valid  in  1  a branch is predicted this cycle.
REQ-007 pred_taken  in  1  direction predicted (the PHT taken output).
REQ-008 pred_ready  out  1  push accepted this cycle.
REQ-009 rd_idx  out  GHB_SIZE  PHT read index: spec_hist XOR pc[GHB_SIZE+1:2].
REQ-010 res_valid  in  1  the oldest in-flight branch resolves this cycle (program order).
REQ-011 res_taken  in  1  actual direction of the resolving branch.
REQ-012 res_mispredict  in  1  the resolving branch was mispredicted.
REQ-013 wb_en  out  1  PHT writeback enable.
REQ-014 wb_idx  out  GHB_SIZE  PHT writeback index, the checkpointed rd_idx of the head entry.
REQ-015 wb_taken  out  1  PHT writeback direction (equal to res_taken).
REQ-016 res_err  out  1  sticky flag: a resolve arrived while the FIFO was empty.

Function
REQ-017 State: spec_hist[GHB_SIZE], arch_hist[GHB_SIZE], FIFO of DEPTH rd_idx entries with head/tail pointers and a count of width log2(DEPTH)+1, FSM {RUN, RECOVER}, res_err.
REQ-018 pred_ready SHALL = (state==RUN) & (count<DEPTH) & ~(res_valid & res_mispredict & count!=0); no same-cycle pop bypass applies when full.
REQ-019 Push (pred_valid & pred_ready): FIFO[tail] <= rd_idx; tail wraps modulo DEPTH; spec_hist <= {spec_hist[GHB_SIZE-2:0], pred_taken}.
REQ-020 pred_valid while pred_ready==0 SHALL be ignored; no state changes.
REQ-021 Pop (res_valid & count!=0): wb_en=1, wb_idx=FIFO[head], wb_taken=res_taken, all combinational in the same cycle; head wraps modulo DEPTH; arch_hist <= {arch_hist[GHB_SIZE-2:0], res_taken}.
REQ-022 Simultaneous push and non-mispredict pop: count unchanged; both pointers advance.
REQ-023 Pop with res_mispredict=1: spec_hist <= {arch_hist[GHB_SIZE-2:0], res_taken}; the FIFO is flushed (head=tail, count=0); state <= RECOVER.
REQ-024 RECOVER lasts exactly one cycle with pred_ready=0, then returns to RUN.
REQ-025 Resolve with count==0: wb_en=0; no history change; res_err <= 1 until reset.
REQ-026 wb_en SHALL be 0 whenever res_valid==0.
REQ-027 res_mispredict is ignored when res_valid==0.

Reset
REQ-028 While reset==0: spec_hist=0, arch_hist=0, head=tail=count=0, state=RUN, res_err=0.
REQ-029 While reset==0: wb_en=0 and pred_ready=0.
REQ-030 While reset==0: rd_idx=pc[GHB_SIZE+1:2].
REQ-031 Reset asserted mid-flush or mid-RECOVER SHALL discard all in-flight entries.

Verification (GHB_SIZE=4, DEPTH=4, pc=0 unless stated)
REQ-032 Reset pulse, then pc=0x3C: rd_idx=4'hF, pred_ready=1, wb_en=0, res_err=0.
REQ-033 Push T, T, N: rd_idx seen at each push = 0000, 0001, 0011; spec_hist afterwards = 0110.
REQ-034 Push 4 branches: pred_ready=0; a 5th pred_valid leaves spec_hist and count unchanged.
REQ-035 Then resolve the head correctly, taken: wb_en=1, wb_idx=0000, wb_taken=1, count=3, arch_hist=0001.
REQ-036 Resolve the next entry with res_taken=0, res_mispredict=1: spec_hist=0010, count=0; pred_ready=0 for 1 cycle, then 1.
REQ-037 res_valid=1 with an empty FIFO: wb_en=0, res_err=1 and held until reset; simultaneous push+pop at count=2 keeps count=2.

Source files
------------

// File: rtl/ghist_ctrl.sv
// ---------------------------------------------------------------------------
// ghist_ctrl -- global-history (gshare) controller for a branch predictor.
//
// The controller keeps a speculative global history that is updated when a
// branch is predicted. It also keeps an architectural history that is
// updated when a branch resolves. Each prediction's PHT read index is saved
// in a checkpoint FIFO so the same PHT entry can be written back at resolve.
// A mispredict rebuilds the speculative history from the architectural one,
// flushes every younger in-flight branch, and stalls prediction for one
// cycle.
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous, active-low
//   pc[31:0]       in   fetch PC of the branch being predicted
//   pred_valid     in   a branch is predicted this cycle
//   pred_taken     in   predicted direction
//   pred_ready     out  push accepted this cycle
//   rd_idx         out  PHT read index = spec_hist ^ pc[GHB_SIZE+1:2]
//   res_valid      in   the oldest in-flight branch resolves this cycle
//   res_taken      in   actual direction of the resolving branch
//   res_mispredict in   the resolving branch was mispredicted
//   wb_en          out  PHT writeback enable
//   wb_idx         out  PHT writeback index (checkpointed rd_idx of the head)
//   wb_taken       out  PHT writeback direction
//   res_err        out  sticky: a resolve arrived while the FIFO was empty
// ---------------------------------------------------------------------------
module ghist_ctrl #(
    parameter int GHB_SIZE = 8,
    parameter int DEPTH    = 8     // power of two, >= 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         pc,
    input  logic                pred_valid,
    input  logic                pred_taken,
    output logic                pred_ready,
    output logic [GHB_SIZE-1:0] rd_idx,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic                res_mispredict,
    output logic                wb_en,
    output logic [GHB_SIZE-1:0] wb_idx,
    output logic                wb_taken,
    output logic                res_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [GHB_SIZE-1:0] spec_hist;
    logic [GHB_SIZE-1:0] arch_hist;
    logic [GHB_SIZE-1:0] fifo [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    logic                not_empty;
    logic                push;
    logic                pop;
    logic                flush;

    // ---------------- combinational datapath ----------------
    assign not_empty = (count != '0);
    assign pop       = res_valid & not_empty;
    assign flush     = pop & res_mispredict;

    // A resolving mispredict blocks the push so the flushed FIFO cannot be
    // refilled with a wrong-path branch in the same cycle. When the FIFO is
    // full, a same-cycle pop does not free a slot for the push.
    // The reset term holds pred_ready low while reset is asserted.
    assign pred_ready = reset
                      & (state == RUN)
                      & (count < CNT_W'(DEPTH))
                      & ~flush;

    assign push     = pred_valid & pred_ready;
    assign rd_idx   = spec_hist ^ pc[GHB_SIZE+1:2];

    assign wb_en    = pop;
    assign wb_idx   = fifo[head];
    assign wb_taken = res_taken;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // RECOVER is a one-cycle bubble. A flush can only start from RUN,
    // because the FIFO is always empty while the FSM is in RECOVER.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // ---------------- history, pointers, count ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spec_hist <= '0;
            arch_hist <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            res_err   <= 1'b0;
        end else begin
            if (res_valid && !not_empty) res_err <= 1'b1;

            if (flush) begin
                // Rebuild the speculative history from the committed history
                // plus the corrected outcome.
                spec_hist <= {arch_hist[GHB_SIZE-2:0], res_taken};
                arch_hist <= {arch_hist[GHB_SIZE-2:0], res_taken};
                head      <= tail;
                count     <= '0;
            end else begin
                if (push) begin
                    tail      <= tail + PTR_W'(1);
                    spec_hist <= {spec_hist[GHB_SIZE-2:0], pred_taken};
                end
                if (pop) begin
                    head      <= head + PTR_W'(1);
                    arch_hist <= {arch_hist[GHB_SIZE-2:0], res_taken};
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: the checkpoint storage has no reset. Entries are only read
    // between head and tail, and those pointers are reset.
    always_ff @(posedge clock) begin
        if (push) fifo[tail] <= rd_idx;
    end

endmodule

// File: tb/tb_ghist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ghist_ctrl -- directed self-checking bench for ghist_ctrl
// (GHB_SIZE=4, DEPTH=4). Inputs change 1 time unit after a rising edge.
// Combinational outputs are sampled 1 unit after that. Registered state is
// sampled 1 unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_ghist_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pred_valid, pred_taken, pred_ready;
    logic [3:0]  rd_idx;
    logic        res_valid, res_taken, res_mispredict;
    logic        wb_en, wb_taken, res_err;
    logic [3:0]  wb_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    ghist_ctrl #(.GHB_SIZE(4), .DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .rd_idx         (rd_idx),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .wb_en          (wb_en),
        .wb_idx         (wb_idx),
        .wb_taken       (wb_taken),
        .res_err        (res_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input logic pt, input logic rv,
                         input logic rt, input logic rm);
        pred_valid     = pv;
        pred_taken     = pt;
        res_valid      = rv;
        res_taken      = rt;
        res_mispredict = rm;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        pc    = 32'h3C;
        // res_valid is high during reset: wb_en must stay low anyway.
        drive(0, 0, 1, 1, 0);
        check("rst_rd_idx",     32'(rd_idx),     32'hF);
        check("rst_pred_ready", 32'(pred_ready), 32'h0);
        check("rst_wb_en",      32'(wb_en),      32'h0);
        tick();
        tick();

        // Release reset away from the clock edge.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("idle_rd_idx",     32'(rd_idx),     32'hF);
        check("idle_pred_ready", 32'(pred_ready), 32'h1);
        check("idle_wb_en",      32'(wb_en),      32'h0);
        check("idle_res_err",    32'(res_err),    32'h0);
        tick();

        // Push T, T, N, T with pc=0.
        pc = 32'h0;
        drive(1, 1, 0, 0, 0);
        check("push1_rd_idx", 32'(rd_idx), 32'h0);
        tick();
        drive(1, 1, 0, 0, 0);
        check("push2_rd_idx", 32'(rd_idx), 32'h1);
        tick();
        drive(1, 0, 0, 0, 0);
        check("push3_rd_idx", 32'(rd_idx), 32'h3);
        tick();
        check("spec_after_TTN", 32'(dut.spec_hist), 32'h6);
        drive(1, 1, 0, 0, 0);
        check("push4_rd_idx", 32'(rd_idx), 32'h6);
        tick();
        check("full_count", 32'(dut.count), 32'h4);

        // FIFO is full: a 5th prediction is ignored.
        drive(1, 0, 0, 0, 0);
        check("full_pred_ready", 32'(pred_ready), 32'h0);
        tick();
        check("ignored_spec",  32'(dut.spec_hist), 32'hD);
        check("ignored_count", 32'(dut.count),     32'h4);

        // Correct taken resolve of the head. pred_valid stays high, but a
        // full FIFO gives no pop bypass.
        drive(1, 0, 1, 1, 0);
        check("res1_wb_en",      32'(wb_en),      32'h1);
        check("res1_wb_idx",     32'(wb_idx),     32'h0);
        check("res1_wb_taken",   32'(wb_taken),   32'h1);
        check("res1_pred_ready", 32'(pred_ready), 32'h0);
        tick();
        check("res1_count", 32'(dut.count),     32'h3);
        check("res1_arch",  32'(dut.arch_hist), 32'h1);
        check("res1_spec",  32'(dut.spec_hist), 32'hD);

        // Mispredicted not-taken resolve of the next entry.
        drive(0, 0, 1, 0, 1);
        check("mis_wb_idx",     32'(wb_idx),     32'h1);
        check("mis_wb_taken",   32'(wb_taken),   32'h0);
        check("mis_pred_ready", 32'(pred_ready), 32'h0);
        tick();
        check("mis_spec",  32'(dut.spec_hist), 32'h2);
        check("mis_count", 32'(dut.count),     32'h0);

        // RECOVER: one cycle with pred_ready low, and a prediction is ignored.
        drive(1, 1, 0, 0, 0);
        check("recover_pred_ready", 32'(pred_ready), 32'h0);
        tick();
        check("recover_spec",  32'(dut.spec_hist), 32'h2);
        check("recover_count", 32'(dut.count),     32'h0);
        drive(0, 0, 0, 0, 0);
        check("run_pred_ready", 32'(pred_ready), 32'h1);
        check("run_rd_idx",     32'(rd_idx),     32'h2);

        // Resolve with an empty FIFO.
        drive(0, 0, 1, 1, 1);
        check("empty_wb_en", 32'(wb_en), 32'h0);
        tick();
        check("empty_res_err", 32'(res_err),       32'h1);
        check("empty_spec",    32'(dut.spec_hist), 32'h2);
        check("empty_arch",    32'(dut.arch_hist), 32'h2);

        // Fill to 2 entries, then do a simultaneous push and correct pop.
        drive(1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        check("fill2_rd_idx", 32'(rd_idx), 32'h5);
        tick();
        drive(1, 1, 1, 1, 0);
        check("pp_rd_idx",     32'(rd_idx),     32'hA);
        check("pp_wb_idx",     32'(wb_idx),     32'h2);
        check("pp_pred_ready", 32'(pred_ready), 32'h1);
        tick();
        check("pp_count",   32'(dut.count),     32'h2);
        check("pp_spec",    32'(dut.spec_hist), 32'h5);
        check("pp_arch",    32'(dut.arch_hist), 32'h5);
        check("pp_res_err", 32'(res_err),       32'h1);

        // Mispredict (enter RECOVER), then an asynchronous reset mid-RECOVER.
        drive(0, 0, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("async_count",      32'(dut.count),     32'h0);
        check("async_res_err",    32'(res_err),       32'h0);
        check("async_spec",       32'(dut.spec_hist), 32'h0);
        check("async_pred_ready", 32'(pred_ready),    32'h0);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_pred_ready", 32'(pred_ready), 32'h1);

        // XOR of PC bits with a nonzero history; pc[5:2] = 0101.
        pc = 32'h14;
        drive(1, 1, 0, 0, 0);
        check("xor_push_rd_idx", 32'(rd_idx), 32'h5);
        tick();
        drive(0, 0, 1, 0, 0);
        check("xor_rd_idx", 32'(rd_idx), 32'h4);
        check("xor_wb_idx", 32'(wb_idx), 32'h5);
        check("xor_wb_en",  32'(wb_en),  32'h1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("final_count", 32'(dut.count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
